// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial add/subtract controller. One full-adder cell is reused for
//   every bit position, LSB first, with the carry held in a flop between
//   bits. A start/busy/done handshake frames each WIDTH-bit operation.
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   reset    : synchronous, active-high reset
//   start    : request an operation (sampled in IDLE only)
//   sub      : 0 -> a+b+cin, 1 -> a-b (cin ignored)
//   a, b     : operands, latched on an accepted start
//   cin      : carry-in for add, latched on an accepted start
//   busy     : high while bits are processed (RUN)
//   done     : one-cycle pulse when the result becomes valid
//   sum      : result register
//   cout     : carry out of the MSB (for sub, 1 = no borrow)
//   overflow : signed overflow (carry into MSB XOR carry out of MSB)

// Single-bit full adder cell shared by the serial datapath.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             carry;
  logic [CW-1:0]    count;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] r_next;

  fulladder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_sum),
    .co (fa_cout)
  );

  // Result shift register input: new bit enters at the MSB, older bits move
  // toward the LSB so that after WIDTH shifts bit 0 sits at position 0.
  generate
    if (WIDTH == 1) begin : g_w1
      assign r_next = fa_sum;
    end else begin : g_wn
      assign r_next = {fa_sum, r_sh[WIDTH-1:1]};
    end
  endgenerate

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Control FSM, serial datapath and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      carry    <= 1'b0;
      count    <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            // Subtraction is a + ~b + 1.
            b_sh  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            count <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          r_sh  <= r_next;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_cout;
          count <= count + CW'(1);
          if (count == LAST) begin
            sum      <= r_next;
            cout     <= fa_cout;
            // carry still holds the carry into the MSB on this edge.
            overflow <= carry ^ fa_cout;
            state    <= DONE;
          end else begin
            state <= RUN;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
